bus_arbiter: RTL and testbench
==============================

// Module: bus_arbiter
// PURPOSE
//  Shares the single memory_bus port (RAM, ROM, peripherals, block RAM) between two
//  requesters: the CPU (port 0) and a DMA/loader engine (port 1).
//  Sequences each access as grant, wait states, then acknowledge, so memory_bus sees
//  one clean transaction at a time. Round-robin fairness, with bounded DMA burst locking.
// PARAMETERS
//  WAIT_CYCLES  1  bus cycles held per access before read data is captured (>=1)
//  MAX_BURST    8  maximum consecutive locked DMA grants while the CPU is waiting (>=1)
// PORTS
//  clk               in   1   system clock; all state on rising edge
//  reset             in   1   asynchronous, active-low reset
//  cpu_req           in   1   CPU access request; hold until cpu_ack
//  cpu_write         in   1   1=write, 0=read
//  cpu_address       in   16  CPU address
//  cpu_data_in       in   16  CPU write data
//  cpu_data_out      out  16  read data; valid from cpu_ack until next cpu_ack
//  cpu_ack           out  1   one-cycle completion pulse
//  dma_req / dma_write / dma_address[16] / dma_data_in[16] / dma_data_out[16] / dma_ack
//                             same semantics as the CPU group
//  dma_lock          in   1   DMA requests back-to-back ownership (burst)
//  bus_address       out  16  to memory_bus address
//  bus_data_out      out  16  to memory_bus data_in
//  bus_data_in       in   16  from memory_bus data_out
//  bus_enable        out  1   to memory_bus bus_enable
//  bus_write_enable  out  1   to memory_bus write_enable
//  grant_dma         out  1   1 while the DMA owns the current transaction
//  busy              out  1   1 in any state other than IDLE
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE; all outputs 0; last_grant=DMA, so the CPU wins the
//   first tie; burst_count=0. Reset mid-access aborts the access: no ack, no write.
//  FSM: IDLE -> ACCESS -> ACK -> IDLE.
//  IDLE: when any req=1, select a winner and latch its address, data and write into bus
//   registers; go to ACCESS next cycle. When no req, stay in IDLE with bus_enable=0.
//  Selection:
//   - Only one requester: that requester wins.
//   - Both requesting: winner = !last_grant.
//   - Exception: when dma_lock=1 and last_grant=DMA and burst_count<MAX_BURST, the DMA wins.
//  burst_count:
//   - increments on each consecutive locked DMA grant;
//   - clears on any CPU grant;
//   - clears on any DMA grant with dma_lock=0.
//  ACCESS: lasts exactly WAIT_CYCLES cycles.
//   - bus_enable=1 and the bus registers are held stable throughout.
//   - bus_write_enable=1 only in the first ACCESS cycle, and only for writes, so each write
//     happens exactly once (peripheral side effects).
//   - For reads, bus_data_in is captured into the winner's data_out register in the last
//     ACCESS cycle. Writes leave data_out unchanged.
//  ACK: winner's ack=1 for exactly one cycle; bus_enable=0. Next state is IDLE, with no
//   back-to-back skip, which gives one idle bus cycle between transactions.
//  Latency: req sampled in IDLE at cycle N -> ack at cycle N+1+WAIT_CYCLES (N+2 default).
//  Request dropped during ACCESS: the transaction still completes and ack still pulses.
//  A requester keeping req high through ack is treated as a new request in the next IDLE.
//  Address/data changes while not in IDLE: ignored until the next IDLE sample.
//  grant_dma is valid in ACCESS and ACK and is 0 in IDLE.
//  The non-winner's ack stays 0, and its data_out holds its previous value.
// STRUCTURE
//  Shared header bus_arbiter_defs.vh: state encodings (IDLE/ACCESS/ACK), requester IDs
//   (REQ_CPU=0, REQ_DMA=1).
//  One sub-module bus_grant_select (combinational): inputs are reqs, last_grant, dma_lock
//   and the burst-limit flag; outputs are winner and valid.
//  Wait counter width $clog2(WAIT_CYCLES+1); burst counter width $clog2(MAX_BURST+1).
// TESTING
//  1. CPU read alone, addr 0x2004, bus_data_in=0xBEEF:
//     -> bus_enable for 1 cycle, cpu_ack at N+2, cpu_data_out=0xBEEF.
//  2. CPU write addr 0x4000 data 0x1234:
//     -> bus_write_enable high for exactly 1 cycle, bus_data_out=0x1234, dma_ack never asserted.
//  3. Both req continuously, dma_lock=0:
//     -> grants alternate CPU, DMA, CPU, DMA; each ack is followed by one idle bus cycle.
//  4. Both req, dma_lock=1, DMA granted first, MAX_BURST=8:
//     -> 8 consecutive DMA grants, then 1 CPU grant, then the DMA resumes.
//  5. reset=0 in the middle of ACCESS on a DMA read:
//     -> outputs go to 0 immediately, no dma_ack, and after release the CPU wins the first tie.
//  6. WAIT_CYCLES=3, cpu_req dropped during ACCESS:
//     -> bus_enable held for 3 cycles, cpu_ack still pulses at N+4.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// Shared types for the two-port memory bus arbiter.
// Holds the FSM state encoding and the requester IDs.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2
  } state_e;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DMA = 1'b1
  } req_id_e;

endpackage

// File: rtl/bus_arbiter_grant_select.sv
// Combinational winner selection for the bus arbiter.
// Ports: cpu_req, dma_req, dma_lock, last_grant, burst_ok in; winner, valid out.
module bus_arbiter_grant_select
  import bus_arbiter_pkg::*;
(
  input  logic    cpu_req,
  input  logic    dma_req,
  input  logic    dma_lock,
  input  req_id_e last_grant,
  input  logic    burst_ok,
  output req_id_e winner,
  output logic    valid
);

  logic both;
  logic hold;

  assign both  = cpu_req & dma_req;
  assign valid = cpu_req | dma_req;

  // A locked DMA keeps the bus on a tie until its burst runs out.
  assign hold = dma_lock & (last_grant == REQ_DMA) & burst_ok;

  always_comb begin
    winner = REQ_CPU;
    unique case (1'b1)
      cpu_req & ~dma_req: winner = REQ_CPU;
      dma_req & ~cpu_req: winner = REQ_DMA;
      both & hold:        winner = REQ_DMA;
      both & ~hold:
        winner = (last_grant == REQ_DMA) ? REQ_CPU : REQ_DMA;
      default:            winner = REQ_CPU;
    endcase
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-port (CPU/DMA) arbiter for the single memory bus.
// Ports: clk, reset (async low), cpu_*/dma_* groups, dma_lock, bus_*, grant_dma, busy.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int MAX_BURST   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_write,
  input  logic [15:0] cpu_address,
  input  logic [15:0] cpu_data_in,
  output logic [15:0] cpu_data_out,
  output logic        cpu_ack,
  input  logic        dma_req,
  input  logic        dma_write,
  input  logic [15:0] dma_address,
  input  logic [15:0] dma_data_in,
  output logic [15:0] dma_data_out,
  output logic        dma_ack,
  input  logic        dma_lock,
  output logic [15:0] bus_address,
  output logic [15:0] bus_data_out,
  input  logic [15:0] bus_data_in,
  output logic        bus_enable,
  output logic        bus_write_enable,
  output logic        grant_dma,
  output logic        busy
);

  localparam int WW = $clog2(WAIT_CYCLES + 1);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_CYCLES - 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

  state_e        state;
  state_e        state_nxt;
  req_id_e       owner;
  req_id_e       last_grant;
  req_id_e       winner;
  logic          win_valid;
  logic          wr_q;
  logic [WW-1:0] wait_cnt;
  logic [BW-1:0] burst_cnt;
  logic          wait_done;

  bus_arbiter_grant_select u_sel (
    .cpu_req    (cpu_req),
    .dma_req    (dma_req),
    .dma_lock   (dma_lock),
    .last_grant (last_grant),
    .burst_ok   (burst_cnt < BURST_MAX),
    .winner     (winner),
    .valid      (win_valid)
  );

  assign wait_done = (wait_cnt == WAIT_LAST);
  assign busy      = (state != ST_IDLE);
  assign grant_dma = busy && (owner == REQ_DMA);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt        = state;
    bus_enable       = 1'b0;
    bus_write_enable = 1'b0;
    cpu_ack          = 1'b0;
    dma_ack          = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (win_valid) state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        bus_enable = 1'b1;
        // Strobe only once so peripheral side effects fire once.
        bus_write_enable = wr_q && (wait_cnt == '0);
        if (wait_done) state_nxt = ST_ACK;
      end
      ST_ACK: begin
        cpu_ack   = (owner == REQ_CPU);
        dma_ack   = (owner == REQ_DMA);
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner        <= REQ_CPU;
      last_grant   <= REQ_DMA;
      burst_cnt    <= '0;
      wait_cnt     <= '0;
      wr_q         <= 1'b0;
      bus_address  <= '0;
      bus_data_out <= '0;
      cpu_data_out <= '0;
      dma_data_out <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (win_valid) begin
            owner      <= winner;
            last_grant <= winner;
            wait_cnt   <= '0;
            if (winner == REQ_DMA) begin
              wr_q         <= dma_write;
              bus_address  <= dma_address;
              bus_data_out <= dma_data_in;
              burst_cnt    <= !dma_lock ? '0 :
                              (burst_cnt == BURST_MAX) ? burst_cnt :
                              burst_cnt + 1'b1;
            end else begin
              wr_q         <= cpu_write;
              bus_address  <= cpu_address;
              bus_data_out <= cpu_data_in;
              burst_cnt    <= '0;
            end
          end
        end
        ST_ACCESS: begin
          if (wait_done) begin
            if (!wr_q && owner == REQ_CPU) cpu_data_out <= bus_data_in;
            if (!wr_q && owner == REQ_DMA) dma_data_out <= bus_data_in;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: transaction model plus directed vectors.
// A second instance with WAIT_CYCLES=3 covers the long-access case.
module tb_bus_arbiter;

  localparam int W  = 1;
  localparam int MB = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_req = 1'b0, cpu_write = 1'b0;
  logic [15:0] cpu_address = '0, cpu_data_in = '0;
  logic        dma_req = 1'b0, dma_write = 1'b0, dma_lock = 1'b0;
  logic [15:0] dma_address = '0, dma_data_in = '0;
  logic [15:0] bus_data_in = '0;

  logic [15:0] cpu_data_out, dma_data_out, bus_address, bus_data_out;
  logic        cpu_ack, dma_ack, bus_enable, bus_write_enable;
  logic        grant_dma, busy;

  logic [15:0] w3_cpu_data_out, w3_dma_data_out, w3_bus_address;
  logic [15:0] w3_bus_data_out;
  logic        w3_cpu_ack, w3_dma_ack, w3_bus_enable, w3_bus_write_enable;
  logic        w3_grant_dma, w3_busy;

  int n_checks = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  bus_arbiter #(.WAIT_CYCLES(W), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_write(cpu_write),
    .cpu_address(cpu_address), .cpu_data_in(cpu_data_in),
    .cpu_data_out(cpu_data_out), .cpu_ack(cpu_ack),
    .dma_req(dma_req), .dma_write(dma_write),
    .dma_address(dma_address), .dma_data_in(dma_data_in),
    .dma_data_out(dma_data_out), .dma_ack(dma_ack),
    .dma_lock(dma_lock),
    .bus_address(bus_address), .bus_data_out(bus_data_out),
    .bus_data_in(bus_data_in), .bus_enable(bus_enable),
    .bus_write_enable(bus_write_enable),
    .grant_dma(grant_dma), .busy(busy)
  );

  bus_arbiter #(.WAIT_CYCLES(3), .MAX_BURST(MB)) dut3 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_write(cpu_write),
    .cpu_address(cpu_address), .cpu_data_in(cpu_data_in),
    .cpu_data_out(w3_cpu_data_out), .cpu_ack(w3_cpu_ack),
    .dma_req(dma_req), .dma_write(dma_write),
    .dma_address(dma_address), .dma_data_in(dma_data_in),
    .dma_data_out(w3_dma_data_out), .dma_ack(w3_dma_ack),
    .dma_lock(dma_lock),
    .bus_address(w3_bus_address), .bus_data_out(w3_bus_data_out),
    .bus_data_in(bus_data_in), .bus_enable(w3_bus_enable),
    .bus_write_enable(w3_bus_write_enable),
    .grant_dma(w3_grant_dma), .busy(w3_busy)
  );

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk16(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction model: m_k counts cycles since the grant edge
  // (1..W access, W+1 acknowledge).
  bit          m_busy = 1'b0, m_own = 1'b0, m_wr = 1'b0, m_last = 1'b1;
  int          m_k = 0, m_burst = 0;
  logic [15:0] m_addr = '0, m_data = '0, m_cpu_out = '0, m_dma_out = '0;

  always @(posedge clk or negedge reset) begin
    bit w;
    if (!reset) begin
      m_busy = 1'b0; m_k = 0; m_own = 1'b0; m_wr = 1'b0;
      m_last = 1'b1; m_burst = 0;
      m_addr = '0; m_data = '0; m_cpu_out = '0; m_dma_out = '0;
    end else if (m_busy) begin
      if (m_k == W && !m_wr) begin
        if (m_own) m_dma_out = bus_data_in;
        else       m_cpu_out = bus_data_in;
      end
      if (m_k == W + 1) m_busy = 1'b0;
      else              m_k++;
    end else if (cpu_req || dma_req) begin
      if (cpu_req && dma_req)
        w = (dma_lock && m_last && m_burst < MB) ? 1'b1 : !m_last;
      else
        w = dma_req;
      m_busy = 1'b1; m_k = 1; m_own = w; m_last = w;
      m_wr   = w ? dma_write : cpu_write;
      m_addr = w ? dma_address : cpu_address;
      m_data = w ? dma_data_in : cpu_data_in;
      if (!w || !dma_lock) m_burst = 0;
      else if (m_burst < MB) m_burst++;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk1("busy", busy, m_busy);
      chk1("bus_enable", bus_enable, m_busy && m_k <= W);
      chk1("bus_write_enable", bus_write_enable, m_busy && m_k == 1 && m_wr);
      chk1("cpu_ack", cpu_ack, m_busy && m_k == W + 1 && !m_own);
      chk1("dma_ack", dma_ack, m_busy && m_k == W + 1 && m_own);
      chk1("grant_dma", grant_dma, m_busy && m_own);
      chk16("bus_address", bus_address, m_addr);
      chk16("bus_data_out", bus_data_out, m_data);
      chk16("cpu_data_out", cpu_data_out, m_cpu_out);
      chk16("dma_data_out", dma_data_out, m_dma_out);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cpu_req = 1'b0; dma_req = 1'b0; dma_lock = 1'b0;
    cpu_write = 1'b0; dma_write = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic run_log(input int ncyc, output bit lg[$]);
    bit prev_ack;
    prev_ack = 1'b0;
    lg.delete();
    for (int i = 0; i < ncyc; i++) begin
      if (prev_ack) chk1("gap_after_ack", busy, 1'b0);
      prev_ack = cpu_ack | dma_ack;
      if (cpu_ack)      lg.push_back(1'b0);
      else if (dma_ack) lg.push_back(1'b1);
      tick();
    end
  endtask

  bit q[$];
  bit t3_exp[4]  = '{0, 1, 0, 1};
  bit t4_exp[11] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 1};
  bit en3[6]     = '{0, 1, 1, 1, 0, 0};
  bit ack3[6]    = '{0, 0, 0, 0, 1, 0};
  int we_n, dack_n;

  initial begin
    tick();
    cmp_en = 1'b1;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_bus_enable", bus_enable, 1'b0);
    chk16("rst_cpu_data_out", cpu_data_out, 16'h0000);
    chk16("rst_bus_address", bus_address, 16'h0000);
    reset = 1'b1;
    tick();

    // 1: CPU read alone
    cpu_address = 16'h2004; cpu_write = 1'b0;
    bus_data_in = 16'hBEEF; cpu_req = 1'b1;
    chk1("t1_idle_en", bus_enable, 1'b0);
    tick();
    chk1("t1_access_en", bus_enable, 1'b1);
    chk16("t1_addr", bus_address, 16'h2004);
    tick();
    chk1("t1_ack", cpu_ack, 1'b1);
    chk1("t1_ack_en", bus_enable, 1'b0);
    chk16("t1_rdata", cpu_data_out, 16'hBEEF);
    cpu_req = 1'b0;
    tick();
    chk1("t1_ack_once", cpu_ack, 1'b0);

    // 2: CPU write
    cpu_address = 16'h4000; cpu_data_in = 16'h1234;
    cpu_write = 1'b1; cpu_req = 1'b1;
    we_n = 0; dack_n = 0;
    for (int i = 0; i < 6; i++) begin
      we_n += int'(bus_write_enable);
      dack_n += int'(dma_ack);
      if (i == 1) chk16("t2_wdata", bus_data_out, 16'h1234);
      if (i == 2) cpu_req = 1'b0;
      tick();
    end
    chk16("t2_we_cycles", 16'(we_n), 16'd1);
    chk16("t2_dma_acks", 16'(dack_n), 16'd0);
    chk16("t2_rdata_kept", cpu_data_out, 16'hBEEF);
    cpu_write = 1'b0;

    // 3: both requesting, no lock -> alternate, CPU first
    do_reset();
    bus_data_in = 16'h0C0D;
    cpu_req = 1'b1; dma_req = 1'b1;
    run_log(12, q);
    cpu_req = 1'b0; dma_req = 1'b0;
    chk16("t3_count", 16'(q.size()), 16'd4);
    for (int i = 0; i < 4 && i < q.size(); i++)
      chk1($sformatf("t3_grant%0d", i), q[i], t3_exp[i]);
    tick();

    // 4: locked DMA burst limited to MB grants
    do_reset();
    dma_lock = 1'b1; cpu_req = 1'b1; dma_req = 1'b1;
    run_log(33, q);
    cpu_req = 1'b0; dma_req = 1'b0; dma_lock = 1'b0;
    chk16("t4_count", 16'(q.size()), 16'd11);
    for (int i = 0; i < 11 && i < q.size(); i++)
      chk1($sformatf("t4_grant%0d", i), q[i], t4_exp[i]);
    tick();

    // 5: reset during a DMA read access
    do_reset();
    dma_address = 16'h1357; dma_write = 1'b0;
    bus_data_in = 16'h7777; dma_req = 1'b1;
    tick();
    chk1("t5_grant", grant_dma, 1'b1);
    chk1("t5_en", bus_enable, 1'b1);
    #2;
    reset = 1'b0; dma_req = 1'b0;
    #1;
    chk1("t5_rst_en", bus_enable, 1'b0);
    chk1("t5_rst_grant", grant_dma, 1'b0);
    chk1("t5_rst_busy", busy, 1'b0);
    chk16("t5_rst_addr", bus_address, 16'h0000);
    dack_n = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      dack_n += int'(dma_ack);
    end
    reset = 1'b1;
    chk16("t5_no_ack", 16'(dack_n), 16'd0);
    chk16("t5_no_data", dma_data_out, 16'h0000);
    cpu_req = 1'b1; dma_req = 1'b1;
    tick();
    chk1("t5_cpu_first", grant_dma, 1'b0);
    chk1("t5_busy", busy, 1'b1);
    tick();
    chk1("t5_cpu_ack", cpu_ack, 1'b1);
    cpu_req = 1'b0; dma_req = 1'b0;
    tick();
    tick();

    // 6: WAIT_CYCLES=3 with request dropped mid-access
    do_reset();
    cpu_address = 16'h00A0; cpu_write = 1'b0;
    bus_data_in = 16'h1111; cpu_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk1($sformatf("t6_en%0d", i), w3_bus_enable, en3[i]);
      chk1($sformatf("t6_ack%0d", i), w3_cpu_ack, ack3[i]);
      if (i == 1) cpu_req = 1'b0;
      if (i == 3) bus_data_in = 16'h5A5A;
      if (i == 4) chk16("t6_rdata", w3_cpu_data_out, 16'h5A5A);
      tick();
    end
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
